// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit.
// The master drives the address, data, lane selects and strobes; the slave returns read data and ack.
interface load_store_unit_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one execute-stage memory op, runs it on a simple ack bus with a WAIT timeout,
// and reports it with a one-cycle done pulse carrying err, the load write-back and its extended data.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] reg2,
  input  logic [4:0]  rd,
  load_store_unit_if.master bus,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic        load_we,
  output logic [4:0]  load_rd,
  output logic [31:0] load_data
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, next_state;
  logic [CW-1:0] count;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic        err_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  sel_q;
  logic        ren_q, wen_q;

  logic        is_load, is_store, accept, legal, misaligned, access_ok, timeout_hit;
  logic [3:0]  sel_next;
  logic [31:0] wdata_next, lane, load_ext;

  assign is_load     = (opcode == OP_LOAD);
  assign is_store    = (opcode == OP_STORE);
  // Reset must pull stall low at once even though it is combinational from the inputs.
  assign accept      = ex_valid && (is_load || is_store) && !rst;
  assign misaligned  = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                       ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
  assign access_ok   = legal && !misaligned;
  assign timeout_hit = (count == CW'(TIMEOUT - 1));

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_ren   = ren_q;
  assign bus.bus_wen   = wen_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    legal      = 1'b0;
    sel_next   = 4'b1111;
    wdata_next = reg2;
    if (is_load) legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else         legal = funct3 inside {3'b000, 3'b001, 3'b010};
    case (funct3[1:0])
      2'b00: begin
        sel_next   = 4'b0001 << alu_result[1:0];
        wdata_next = {4{reg2[7:0]}};
      end
      2'b01: begin
        sel_next   = 4'b0011 << {alu_result[1], 1'b0};
        wdata_next = {2{reg2[15:0]}};
      end
      default: begin
        sel_next   = 4'b1111;
        wdata_next = reg2;
      end
    endcase
  end

  always_comb begin
    lane     = bus.bus_rdata >> {addr_lo, 3'b000};
    load_ext = bus.bus_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    load_we    = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall      = 1'b1;
        next_state = access_ok ? WAIT : DONE;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.bus_ack || timeout_hit) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        err        = err_q;
        load_we    = we_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      addr_lo   <= '0;
      funct3_q  <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      load_rd   <= '0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          count    <= '0;
          addr_lo  <= alu_result[1:0];
          funct3_q <= funct3;
          load_rd  <= rd;
          if (access_ok) begin
            addr_q  <= {alu_result[31:2], 2'b00};
            sel_q   <= sel_next;
            wdata_q <= wdata_next;
            ren_q   <= is_load;
            wen_q   <= is_store;
            err_q   <= 1'b0;
            we_q    <= is_load;
          end else begin
            err_q     <= 1'b1;
            we_q      <= 1'b0;
            load_data <= '0;
          end
        end
        WAIT: begin
          if (bus.bus_ack) begin
            ren_q <= 1'b0;
            wen_q <= 1'b0;
            if (we_q) load_data <= load_ext;
          end else if (timeout_hit) begin
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            err_q     <= 1'b1;
            we_q      <= 1'b0;
            load_data <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4): loads, stores, misalignment, illegal ops,
// bus timeout and reset in the middle of a WAIT.
module tb_load_store_unit;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] alu_result, reg2;
  logic [4:0]  rd;
  logic        stall, done, err, load_we;
  logic [4:0]  load_rd;
  logic [31:0] load_data;

  int checks   = 0;
  int failures = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_result (alu_result),
    .reg2       (reg2),
    .rd         (rd),
    .bus        (bus_if.master),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .load_we    (load_we),
    .load_rd    (load_rd),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    ex_valid   = 1'b0;
    opcode     = '0;
    funct3     = '0;
    alu_result = '0;
    reg2       = '0;
    rd         = '0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input logic [4:0] r);
    ex_valid   = 1'b1;
    opcode     = op;
    funct3     = f3;
    alu_result = addr;
    reg2       = data;
    rd         = r;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    issue(OP_LOAD, 3'b010, 32'h0, 32'h0, 5'd1);
    #1;
    check("rst_stall",   stall, 0);
    check("rst_done",    done, 0);
    check("rst_ren",     bus_if.bus_ren, 0);
    check("rst_wen",     bus_if.bus_wen, 0);
    check("rst_sel",     bus_if.bus_sel, 0);
    check("rst_ldata",   load_data, 0);
    idle_in();
    tick();
    tick();
    rst = 1'b0;

    // LB at 0x1003, ack in the second WAIT cycle
    tick();
    issue(OP_LOAD, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
    #1;
    check("lb_stall_acc", stall, 1);
    check("lb_ren_acc",   bus_if.bus_ren, 0);
    tick();
    idle_in();
    #1;
    check("lb_w1_stall", stall, 1);
    check("lb_w1_ren",   bus_if.bus_ren, 1);
    check("lb_w1_wen",   bus_if.bus_wen, 0);
    check("lb_w1_addr",  bus_if.bus_addr, 32'h0000_1000);
    check("lb_w1_sel",   bus_if.bus_sel, 4'b1000);
    check("lb_w1_done",  done, 0);
    tick();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h80FF_FF7F;
    #1;
    check("lb_w2_stall", stall, 1);
    check("lb_w2_ren",   bus_if.bus_ren, 1);
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    #1;
    check("lb_done",     done, 1);
    check("lb_err",      err, 0);
    check("lb_we",       load_we, 1);
    check("lb_rd",       load_rd, 5'd5);
    check("lb_data",     load_data, 32'hFFFF_FF80);
    check("lb_d_stall",  stall, 0);
    check("lb_d_ren",    bus_if.bus_ren, 0);
    tick();
    #1;
    check("lb_idle_done", done, 0);
    check("lb_idle_we",   load_we, 0);
    check("lb_idle_hold", load_data, 32'hFFFF_FF80);

    // SH at 0x2002; a load offered during WAIT/DONE and an ack in DONE/IDLE are ignored
    issue(OP_STORE, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
    tick();
    issue(OP_LOAD, 3'b010, 32'h0000_0100, 32'h0, 5'd9);
    bus_if.bus_ack = 1'b1;
    #1;
    check("sh_wen",   bus_if.bus_wen, 1);
    check("sh_ren",   bus_if.bus_ren, 0);
    check("sh_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
    check("sh_sel",   bus_if.bus_sel, 4'b1100);
    check("sh_addr",  bus_if.bus_addr, 32'h0000_2000);
    check("sh_stall", stall, 1);
    tick();
    ex_valid = 1'b0;
    #1;
    check("sh_done",     done, 1);
    check("sh_err",      err, 0);
    check("sh_we",       load_we, 0);
    check("sh_d_wen",    bus_if.bus_wen, 0);
    check("sh_d_stall",  stall, 0);
    tick();
    #1;
    check("sh_idle_done",  done, 0);
    check("sh_idle_stall", stall, 0);
    check("sh_idle_ren",   bus_if.bus_ren, 0);
    tick();
    bus_if.bus_ack = 1'b0;
    #1;
    check("sh_ack_idle_done", done, 0);

    // Misaligned LW at 0x0006
    issue(OP_LOAD, 3'b010, 32'h0000_0006, 32'h0, 5'd7);
    #1;
    check("lw_mis_stall", stall, 1);
    tick();
    idle_in();
    #1;
    check("lw_mis_done", done, 1);
    check("lw_mis_err",  err, 1);
    check("lw_mis_we",   load_we, 0);
    check("lw_mis_data", load_data, 0);
    check("lw_mis_ren",  bus_if.bus_ren, 0);
    check("lw_mis_rd",   load_rd, 5'd7);
    tick();
    #1;
    check("lw_mis_idle_done", done, 0);
    check("lw_mis_idle_err",  err, 0);

    // LHU at 0x3002 with no ack: four strobed WAIT cycles then a timeout error
    issue(OP_LOAD, 3'b101, 32'h0000_3002, 32'h0, 5'd3);
    tick();
    idle_in();
    #1;
    check("to_w1_ren", bus_if.bus_ren, 1);
    check("to_w1_sel", bus_if.bus_sel, 4'b1100);
    for (int i = 2; i <= 4; i++) begin
      tick();
      #1;
      check($sformatf("to_w%0d_ren", i), bus_if.bus_ren, 1);
      check($sformatf("to_w%0d_done", i), done, 0);
    end
    tick();
    #1;
    check("to_done",  done, 1);
    check("to_err",   err, 1);
    check("to_we",    load_we, 0);
    check("to_ren",   bus_if.bus_ren, 0);
    check("to_stall", stall, 0);
    tick();
    #1;
    check("to_idle_done",  done, 0);
    check("to_idle_stall", stall, 0);

    // SW interrupted by reset in WAIT, then LBU at 0x0001
    issue(OP_STORE, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 5'd0);
    tick();
    idle_in();
    #1;
    check("sw_wen",   bus_if.bus_wen, 1);
    check("sw_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
    check("sw_sel",   bus_if.bus_sel, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check("sw_rst_wen",   bus_if.bus_wen, 0);
    check("sw_rst_stall", stall, 0);
    check("sw_rst_done",  done, 0);
    check("sw_rst_rd",    load_rd, 0);
    tick();
    rst = 1'b0;
    #1;
    check("sw_after_done", done, 0);
    tick();
    #1;
    check("sw_after2_done", done, 0);
    issue(OP_LOAD, 3'b100, 32'h0000_0001, 32'h0, 5'd9);
    tick();
    idle_in();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h0000_9900;
    #1;
    check("lbu_ren",  bus_if.bus_ren, 1);
    check("lbu_sel",  bus_if.bus_sel, 4'b0010);
    check("lbu_addr", bus_if.bus_addr, 32'h0);
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    #1;
    check("lbu_done", done, 1);
    check("lbu_err",  err, 0);
    check("lbu_we",   load_we, 1);
    check("lbu_rd",   load_rd, 5'd9);
    check("lbu_data", load_data, 32'h0000_0099);
    tick();

    // Illegal store funct3, then a non-memory opcode
    issue(OP_STORE, 3'b011, 32'h0000_5000, 32'h1111_2222, 5'd0);
    #1;
    check("ill_stall", stall, 1);
    tick();
    idle_in();
    #1;
    check("ill_done", done, 1);
    check("ill_err",  err, 1);
    check("ill_wen",  bus_if.bus_wen, 0);
    check("ill_ren",  bus_if.bus_ren, 0);
    tick();
    issue(OP_ALU, 3'b000, 32'h0000_6000, 32'h0, 5'd4);
    #1;
    check("alu_stall", stall, 0);
    tick();
    #1;
    check("alu_done",  done, 0);
    check("alu_stall2", stall, 0);
    check("alu_ren",   bus_if.bus_ren, 0);
    check("alu_wen",   bus_if.bus_wen, 0);
    idle_in();
    tick();
    #1;
    check("alu_done2", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
